// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared UART definitions: FSM state encoding, baud helper and the
//           default line-rate constants used by both the TX and RX sides.
//  Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ    = 100_000_000;
    localparam int DEFAULT_BAUD_RATE   = 9600;
    localparam int DEFAULT_DATA_LENGTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Integer divide on purpose: the residual baud error is accepted.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module : uart_baud_tick
//  Brief  : Clearable bit-period counter; bit_end is high for the last clock
//           of every CLKS_PER_BIT-cycle bit period while enabled.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int                c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign bit_end = enable && !clear && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module : uart_tx_serializer
//  Brief  : 8N1-style UART transmitter with a one-deep holding register so a
//           start arriving mid-frame is sent back-to-back with no idle gap.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE   = DEFAULT_BAUD_RATE,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] data,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int                 c_clks_per_bit = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int                 c_bit_w        = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [c_bit_w-1:0] c_last_bit     = c_bit_w'(DATA_LENGTH - 1);
    localparam logic [c_bit_w-1:0] c_last_stop    = c_bit_w'(STOP_BITS - 1);

    tx_state_t              r_state;
    logic [DATA_LENGTH-1:0] r_shift;
    logic [DATA_LENGTH-1:0] r_hold;
    logic                   r_hold_valid;
    logic [c_bit_w-1:0]     r_bit_cnt;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;

    logic w_bit_end;
    logic w_active;
    logic w_frame_end;
    logic w_direct_load;

    assign w_active      = (r_state != ST_IDLE);
    assign w_frame_end   = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == c_last_stop);
    // With the hold empty, a start on the final stop edge becomes the next frame directly.
    assign w_direct_load = w_frame_end && !r_hold_valid;

    uart_baud_tick #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_active),
        .clear   (!w_active),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_bit_cnt    <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= data;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_tx      <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_frame_end) begin
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        if (r_hold_valid) begin
                            r_shift      <= r_hold;
                            r_hold_valid <= 1'b0;
                            r_tx         <= 1'b0;
                            r_state      <= ST_START;
                        end else if (start) begin
                            r_shift <= data;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Mid-frame requests: park one word, drop and flag anything beyond that.
            if (start && w_active && !w_direct_load) begin
                if (!r_hold_valid) begin
                    r_hold       <= data;
                    r_hold_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
`default_nettype wire
